// File: rtl/regfile_sb_pkg.sv
// Shared defaults and types for the Subarashii register file with scoreboard.
package regfile_sb_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_NREAD = 2;
  localparam int unsigned ZERO_REG  = 0;

  // Which source feeds a read lane this cycle.
  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_BYPASS,
    SRC_ZERO
  } rd_src_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read lane: address mux, zero-register override and write-through bypass.
module regfile_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic [AW-1:0]                sel_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem_i,
  input  logic [DEPTH-1:0]             busy_i,
  input  logic                         wen_i,
  input  logic [AW-1:0]                wsel_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         rbusy_o
);

  rd_src_e src;

  // Zero-register override takes priority over the bypass compare.
  always_comb begin
    src = SRC_MEM;
    if (ZERO_R0 != 0 && sel_i == AW'(ZERO_REG)) begin
      src = SRC_ZERO;
    end else if (BYPASS != 0 && wen_i && wsel_i == sel_i) begin
      src = SRC_BYPASS;
    end
  end

  always_comb begin
    rdata_o = mem_i[sel_i];
    rbusy_o = busy_i[sel_i];
    case (src)
      SRC_ZERO: begin
        rdata_o = '0;
        rbusy_o = 1'b0;
      end
      SRC_BYPASS: begin
        rdata_o = wdata_i;
        rbusy_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass, optional
// hardwired r0 and a per-register busy scoreboard for hazard detection.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned NREAD   = DEF_NREAD,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [AW-1:0]           selRd,
  input  logic [WIDTH-1:0]        rd,
  input  logic                    claimEn,
  input  logic [AW-1:0]           claimSel,
  input  logic [NREAD*AW-1:0]     selR,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  output logic                    anyBusy
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        wr_ok, clm_ok, byp_wen;

  always_comb begin
    wr_ok  = wen     && !(ZERO_R0 != 0 && selRd    == AW'(ZERO_REG));
    clm_ok = claimEn && !(ZERO_R0 != 0 && claimSel == AW'(ZERO_REG));
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[selRd]  = rd;
      busy_d[selRd] = 1'b0;
    end
    // Claim is applied after the write so a same-register claim wins.
    if (clm_ok) begin
      busy_d[claimSel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Bypass is suppressed during reset so every lane reads zero while rst is high.
  assign byp_wen = wen && !rst;
  assign anyBusy = |busy_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .sel_i   (selR[g*AW +: AW]),
      .mem_i   (mem_q),
      .busy_i  (busy_q),
      .wen_i   (byp_wen),
      .wsel_i  (selRd),
      .wdata_i (rd),
      .rdata_o (rdata[g*WIDTH +: WIDTH]),
      .rbusy_o (rbusy[g])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 3-lane bypassing instance and a 2-lane
// non-bypassing instance share clock and reset.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_wen = 1'b0, a_claimEn = 1'b0;
  logic [3:0]  a_selRd = '0, a_claimSel = '0;
  logic [15:0] a_rd = '0;
  logic [11:0] a_selR = '0;
  logic [47:0] a_rdata;
  logic [2:0]  a_rbusy;
  logic        a_anyBusy;

  logic        b_wen = 1'b0, b_claimEn = 1'b0;
  logic [3:0]  b_selRd = '0, b_claimSel = '0;
  logic [15:0] b_rd = '0;
  logic [7:0]  b_selR = '0;
  logic [31:0] b_rdata;
  logic [1:0]  b_rbusy;
  logic        b_anyBusy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(16), .NREAD(3), .ZERO_R0(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wen(a_wen), .selRd(a_selRd), .rd(a_rd),
    .claimEn(a_claimEn), .claimSel(a_claimSel), .selR(a_selR),
    .rdata(a_rdata), .rbusy(a_rbusy), .anyBusy(a_anyBusy)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(16), .NREAD(2), .ZERO_R0(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wen(b_wen), .selRd(b_selRd), .rd(b_rd),
    .claimEn(b_claimEn), .claimSel(b_claimSel), .selR(b_selR),
    .rdata(b_rdata), .rbusy(b_rbusy), .anyBusy(b_anyBusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (a_rdata !== 48'h0 || a_anyBusy !== 1'b0 || a_rbusy !== 3'b0) begin
      fails++;
      $display("FAIL reset_a: rdata=%h rbusy=%b anyBusy=%b, want all 0", a_rdata, a_rbusy, a_anyBusy);
    end
    tests++;
    if (b_rdata !== 32'h0 || b_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: rdata=%h anyBusy=%b, want all 0", b_rdata, b_anyBusy);
    end
    // Write and claim during reset must be discarded and not bypassed.
    a_wen = 1'b1; a_selRd = 4'd3; a_rd = 16'hBEEF; a_selR = {4'd0, 4'd0, 4'd3};
    a_claimEn = 1'b1; a_claimSel = 4'd2;
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h0) begin
      fails++;
      $display("FAIL reset_nobypass: got %h want 0000", a_rdata[15:0]);
    end
    tick();
    rst = 1'b0;
    a_wen = 1'b0; a_claimEn = 1'b0;
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h0 || a_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: r3=%h anyBusy=%b want 0000/0", a_rdata[15:0], a_anyBusy);
    end
    // Load state, then pulse reset between edges.
    a_wen = 1'b1; a_selRd = 4'd3; a_rd = 16'h55AA;
    a_claimEn = 1'b1; a_claimSel = 4'd2;
    b_wen = 1'b1; b_selRd = 4'd6; b_rd = 16'h6666; b_selR = {4'd0, 4'd6};
    tick();
    a_wen = 1'b0; a_claimEn = 1'b0; b_wen = 1'b0;
    a_selR = {4'd0, 4'd2, 4'd3};
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h55AA || a_rbusy[1] !== 1'b1 || a_anyBusy !== 1'b1) begin
      fails++;
      $display("FAIL preload: r3=%h busy2=%b any=%b want 55aa/1/1", a_rdata[15:0], a_rbusy[1], a_anyBusy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (a_rdata !== 48'h0 || a_rbusy !== 3'b0 || a_anyBusy !== 1'b0 || b_rdata !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: a=%h rbusy=%b any=%b b=%h want all 0", a_rdata, a_rbusy, a_anyBusy, b_rdata);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [15:0] exp0, exp1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      a_wen = 1'b1; a_selRd = 4'(i); a_rd = 16'hA000 + 16'(i);
      tick();
    end
    a_wen = 1'b0;
    for (int i = 1; i < 16; i++) begin
      a_selR = {4'd0, 4'(i - 1), 4'(i)};
      #1;
      exp0 = 16'hA000 + 16'(i);
      exp1 = (i == 1) ? 16'h0000 : 16'hA000 + 16'(i - 1);
      tests++;
      if (a_rdata[15:0] !== exp0 || a_rdata[31:16] !== exp1 || a_rdata[47:32] !== 16'h0) begin
        fails++;
        $display("FAIL sweep[%0d]: got %h %h %h want %h %h 0000", i,
                 a_rdata[15:0], a_rdata[31:16], a_rdata[47:32], exp0, exp1);
      end
    end
    a_wen = 1'b1; a_selRd = 4'd0; a_rd = 16'hFFFF; a_selR = {4'd0, 4'd0, 4'd0};
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h0) begin
      fails++;
      $display("FAIL r0_bypass: got %h want 0000", a_rdata[15:0]);
    end
    tick();
    a_wen = 1'b0;
    #1;
    tests++;
    if (a_rdata !== 48'h0) begin
      fails++;
      $display("FAIL r0_write: got %h want 0", a_rdata);
    end
  endtask

  task automatic test_bypass();
    a_claimEn = 1'b1; a_claimSel = 4'd5; a_selR = {4'd0, 4'd0, 4'd5};
    tick();
    a_claimEn = 1'b0;
    #1;
    tests++;
    if (a_rbusy[0] !== 1'b1 || a_rdata[15:0] !== 16'hA005) begin
      fails++;
      $display("FAIL bypass_pre: busy=%b data=%h want 1/a005", a_rbusy[0], a_rdata[15:0]);
    end
    a_wen = 1'b1; a_selRd = 4'd5; a_rd = 16'h1234;
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h1234 || a_rbusy[0] !== 1'b0) begin
      fails++;
      $display("FAIL bypass_same_cycle: data=%h busy=%b want 1234/0", a_rdata[15:0], a_rbusy[0]);
    end
    tick();
    a_wen = 1'b0;
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h1234 || a_rbusy[0] !== 1'b0 || a_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL bypass_after: data=%h busy=%b any=%b want 1234/0/0", a_rdata[15:0], a_rbusy[0], a_anyBusy);
    end
    b_wen = 1'b1; b_selRd = 4'd5; b_rd = 16'h0BAD;
    tick();
    b_rd = 16'h1234; b_selR = {4'd0, 4'd5};
    #1;
    tests++;
    if (b_rdata[15:0] !== 16'h0BAD) begin
      fails++;
      $display("FAIL nobypass_before: got %h want 0bad", b_rdata[15:0]);
    end
    tick();
    b_wen = 1'b0;
    #1;
    tests++;
    if (b_rdata[15:0] !== 16'h1234) begin
      fails++;
      $display("FAIL nobypass_after: got %h want 1234", b_rdata[15:0]);
    end
  endtask

  task automatic test_scoreboard();
    a_claimEn = 1'b1; a_claimSel = 4'd7; a_selR = {4'd0, 4'd0, 4'd7};
    #1;
    tests++;
    if (a_rbusy[0] !== 1'b0 || a_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL claim_comb: rbusy=%b any=%b want 0/0", a_rbusy[0], a_anyBusy);
    end
    tick();
    a_claimEn = 1'b0;
    #1;
    tests++;
    if (a_rbusy[0] !== 1'b1 || a_anyBusy !== 1'b1) begin
      fails++;
      $display("FAIL claim: rbusy=%b any=%b want 1/1", a_rbusy[0], a_anyBusy);
    end
    a_wen = 1'b1; a_selRd = 4'd7; a_rd = 16'h0042;
    #1;
    tests++;
    if (a_anyBusy !== 1'b1) begin
      fails++;
      $display("FAIL anybusy_nobypass: got %b want 1", a_anyBusy);
    end
    tick();
    a_wen = 1'b0;
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h0042 || a_rbusy[0] !== 1'b0 || a_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL release: data=%h busy=%b any=%b want 0042/0/0", a_rdata[15:0], a_rbusy[0], a_anyBusy);
    end
  endtask

  task automatic test_claim_write();
    a_claimEn = 1'b1; a_claimSel = 4'd9;
    a_wen = 1'b1; a_selRd = 4'd9; a_rd = 16'h9999;
    tick();
    a_claimEn = 1'b0; a_wen = 1'b0; a_selR = {4'd0, 4'd0, 4'd9};
    #1;
    tests++;
    if (a_rdata[15:0] !== 16'h9999 || a_rbusy[0] !== 1'b1) begin
      fails++;
      $display("FAIL claim_write_same: data=%h busy=%b want 9999/1", a_rdata[15:0], a_rbusy[0]);
    end
    a_wen = 1'b1; a_selRd = 4'd9; a_rd = 16'h0909;
    a_claimEn = 1'b1; a_claimSel = 4'd4;
    tick();
    a_wen = 1'b0; a_claimEn = 1'b0; a_selR = {4'd0, 4'd4, 4'd9};
    #1;
    tests++;
    if (a_rbusy[1:0] !== 2'b10 || a_rdata[15:0] !== 16'h0909) begin
      fails++;
      $display("FAIL release9_claim4: rbusy=%b r9=%h want 10/0909", a_rbusy[1:0], a_rdata[15:0]);
    end
    a_claimEn = 1'b1; a_claimSel = 4'd3;
    a_wen = 1'b1; a_selRd = 4'd4; a_rd = 16'h4444;
    tick();
    a_wen = 1'b0; a_claimEn = 1'b0; a_selR = {4'd0, 4'd4, 4'd3};
    #1;
    tests++;
    if (a_rbusy[1:0] !== 2'b01 || a_rdata[31:16] !== 16'h4444 || a_anyBusy !== 1'b1) begin
      fails++;
      $display("FAIL claim3_write4: rbusy=%b r4=%h any=%b want 01/4444/1", a_rbusy[1:0], a_rdata[31:16], a_anyBusy);
    end
    a_wen = 1'b1; a_selRd = 4'd3; a_rd = 16'h3333;
    tick();
    a_wen = 1'b0;
    #1;
    tests++;
    if (a_anyBusy !== 1'b0 || a_rdata[15:0] !== 16'h3333) begin
      fails++;
      $display("FAIL cleanup: any=%b r3=%h want 0/3333", a_anyBusy, a_rdata[15:0]);
    end
  endtask

  task automatic test_zero_claim();
    a_claimEn = 1'b1; a_claimSel = 4'd0; a_selR = {4'd0, 4'd0, 4'd0};
    b_claimEn = 1'b1; b_claimSel = 4'd0;
    tick();
    a_claimEn = 1'b0; b_claimEn = 1'b0;
    #1;
    tests++;
    if (a_anyBusy !== 1'b0 || a_rbusy !== 3'b0 || b_anyBusy !== 1'b0) begin
      fails++;
      $display("FAIL zero_claim: a_any=%b a_rbusy=%b b_any=%b want 0/000/0", a_anyBusy, a_rbusy, b_anyBusy);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_bypass();
    test_scoreboard();
    test_claim_write();
    test_zero_claim();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
